// File: rtl/flick_pkg.sv
// Shared types and constants for the FLICK button front-end.
// Imported by flick_conditioner; sync_2ff is kept type-free for reuse.
package flick_pkg;

  localparam int unsigned PRESS_CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } flick_state_e;

  // Bits needed to hold counts 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flick_conditioner_sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset, for any
// asynchronous single-bit input entering the system clock domain.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/flick_conditioner.sv
// Debounces a raw push-button into a clean one-cycle FLICK pulse per press,
// with optional auto-repeat while held, a debounced level and a press counter.
module flick_conditioner
  import flick_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   BTN_RAW,
  output logic                   FLICK,
  output logic                   BTN_LEVEL,
  output logic [PRESS_CNT_W-1:0] PRESS_CNT
);

  localparam int unsigned DcntW = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned RcntW = cnt_w(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam bit          RepeatEn = (REPEAT_DELAY != 0);

  localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RcntW-1:0] RDelayLast =
      RcntW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [RcntW-1:0] RPeriodLast =
      RcntW'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);

  logic sync2;

  flick_state_e state_q, state_d;
  logic [DcntW-1:0]       dcnt_q, dcnt_d;
  logic [RcntW-1:0]       rcnt_q, rcnt_d;
  logic                   later_q, later_d;
  logic                   flick_q, flick_d;
  logic                   level_q, level_d;
  logic [PRESS_CNT_W-1:0] cnt_q, cnt_d;
  logic [RcntW-1:0]       rterm;

  sync_2ff u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (BTN_RAW),
    .q_o   (sync2)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (sync2) state_d = StPressWait;
      end
      StPressWait: begin
        if (!sync2) begin
          state_d = StIdle;
        end else if (dcnt_q == DcntLast) begin
          state_d = StPressed;
        end
      end
      StPressed: begin
        if (!sync2) state_d = StReleaseWait;
      end
      StReleaseWait: begin
        if (sync2) begin
          state_d = StPressed;
        end else if (dcnt_q == DcntLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // later_q selects the steady repeat period once the first repeat has fired.
  assign rterm = later_q ? RPeriodLast : RDelayLast;

  always_comb begin
    dcnt_d  = dcnt_q;
    rcnt_d  = rcnt_q;
    later_d = later_q;
    flick_d = 1'b0;
    level_d = level_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        level_d = 1'b0;
        dcnt_d  = '0;
      end
      StPressWait: begin
        if (sync2) begin
          if (dcnt_q == DcntLast) begin
            flick_d = 1'b1;
            level_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            rcnt_d  = '0;
            later_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      StPressed: begin
        if (!sync2) begin
          dcnt_d = '0;
        end else if (RepeatEn) begin
          // Holding off one cycle after a pulse keeps FLICK from ever
          // being high on two consecutive edges when the period is 1.
          if (rcnt_q == rterm) begin
            if (!flick_q) begin
              flick_d = 1'b1;
              rcnt_d  = '0;
              later_d = 1'b1;
            end
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      StReleaseWait: begin
        if (!sync2) begin
          if (dcnt_q == DcntLast) begin
            level_d = 1'b0;
            rcnt_d  = '0;
            later_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: begin
        level_d = 1'b0;
        dcnt_d  = '0;
        rcnt_d  = '0;
        later_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      later_q <= 1'b0;
      flick_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      later_q <= later_d;
      flick_q <= flick_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign FLICK     = flick_q;
  assign BTN_LEVEL = level_q;
  assign PRESS_CNT = cnt_q;

endmodule

// File: doc/flick_conditioner.md
Name: flick_conditioner

Overview:
- Upstream front-end for the LED flasher's FLICK input.
- Takes a raw, asynchronous, bouncy push-button signal and synchronises it into CLK with a 2-FF synchroniser.
- Debounces it with a counter-based state machine.
- Emits a clean single-cycle FLICK pulse per accepted press, with optional auto-repeat while held, plus a debounced level and a wrap-around press counter for debug.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable synchronised cycles needed to accept a press or release; legal range 1..65535.
- REPEAT_DELAY, default 0: cycles from the first pulse to the first auto-repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, default 8: cycles between subsequent auto-repeat pulses; legal range ≥1, ignored when REPEAT_DELAY=0.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- BTN_RAW  input  1  raw asynchronous button level; 1 = pressed.
- FLICK  output  1  one-cycle registered pulse per accepted press or repeat; drives the flasher's FLICK.
- BTN_LEVEL  output  1  debounced button level, registered.
- PRESS_CNT  output  8  count of accepted initial presses; excludes repeats.

Behaviour:
- Reset: at any rising edge with RST=1, the following are cleared:
  - sync1, sync2, state (IDLE), debounce counter, repeat counter
  - FLICK=0, BTN_LEVEL=0, PRESS_CNT=0
- RST overrides all other activity, including mid-debounce, mid-repeat and a pulse scheduled for that edge.
- Synchroniser: sync1 <= BTN_RAW, sync2 <= sync1. The FSM uses sync2 only.
- IDLE (BTN_LEVEL=0):
  - sync2=1 -> PRESS_WAIT, dcnt=0.
- PRESS_WAIT:
  - sync2=0 -> IDLE (glitch rejected, no pulse).
  - Otherwise, if dcnt==DEBOUNCE_CYCLES-1 -> PRESSED, FLICK<=1, PRESS_CNT<=PRESS_CNT+1, rcnt=0.
  - Otherwise dcnt++.
- PRESSED (BTN_LEVEL=1):
  - sync2=0 -> RELEASE_WAIT, dcnt=0; rcnt is frozen.
  - Otherwise, if REPEAT_DELAY≠0, rcnt++.
  - When rcnt reaches REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats), FLICK<=1 and rcnt<=0.
  - A first/later flag selects the terminal value.
- RELEASE_WAIT (BTN_LEVEL stays 1):
  - sync2=1 -> PRESSED; no pulse, PRESS_CNT unchanged, rcnt resumes from its frozen value.
  - Otherwise, if dcnt==DEBOUNCE_CYCLES-1 -> IDLE; BTN_LEVEL<=0, rcnt and the repeat flag are cleared.
  - Otherwise dcnt++.
- FLICK is 0 on every edge that does not explicitly set it, so it is never high for two consecutive cycles. With REPEAT_PERIOD=1 it can be high on alternate cycles at minimum.
- Press latency: if edge N is the first edge sampling BTN_RAW=1 and BTN_RAW stays 1, then the state becomes PRESSED and FLICK is high at edge N+2+DEBOUNCE_CYCLES.
  - Example: DEBOUNCE_CYCLES=4 -> FLICK high at N+6.
- Acceptance threshold: BTN_RAW must be sampled high on DEBOUNCE_CYCLES+1 consecutive edges; shorter highs produce no FLICK. Release is symmetric, so BTN_LEVEL falls at edge M+2+DEBOUNCE_CYCLES after the first low sample M.
- PRESS_CNT wraps modulo 256 (255 -> 0) without a flag.
- Counter widths come from $clog2 of the parameters and must not overflow for legal values.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Shared package flick_pkg holds:
  - the state typedef: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT (2-bit);
  - PRESS_CNT_W=8.
- One natural sub-module, sync_2ff: a 2-flop synchroniser with synchronous active-high reset. It is reusable for the flasher's other asynchronous inputs.
- FSM, counters and outputs live in flick_conditioner.

Test Plan:
- Reset: RST=1 for 2 edges with BTN_RAW=1 -> FLICK=0, BTN_LEVEL=0, PRESS_CNT=0 throughout. After release of RST, FLICK at the 6th edge (DEBOUNCE_CYCLES=4).
- Clean press: BTN_RAW rises before edge 10 and is held 20 cycles, then falls before edge 30 -> FLICK high only at edge 16; BTN_LEVEL 1 from edge 16 to edge 35, 0 at edge 36; PRESS_CNT=1.
- Bounce rejection: BTN_RAW high for 4 edges, low for 1, repeated 5 times, then held high -> no FLICK during bounce; exactly one FLICK at 6 edges after the final rise is first sampled.
- Release bounce: while PRESSED, drop BTN_RAW for 2 edges, then hold high -> BTN_LEVEL stays 1, no extra FLICK, PRESS_CNT unchanged.
- Auto-repeat: REPEAT_DELAY=10, REPEAT_PERIOD=4, hold 30 cycles after the first pulse at edge T -> FLICK at T, T+10, T+14, T+18, T+22, T+26, T+30; PRESS_CNT +1 only.
- Wrap and mid-operation reset: 256 clean presses -> PRESS_CNT=0. Then assert RST during PRESS_WAIT -> no FLICK, state IDLE, and a subsequent press requires full latency again.
